// File: rtl/mac_pkg.sv
// Shared MAC datatypes plus decode-arbiter state and field types.
package mac_pkg;

    typedef enum logic [1:0] {
        MAC_DATATYPE_INT8 = 2'd0,
        MAC_DATATYPE_FP8  = 2'd1,
        MAC_DATATYPE_INT9 = 2'd2,
        MAC_DATATYPE_RSVD = 2'd3
    } mac_datatype;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } mac_dec_arb_state;

    typedef struct packed {
        logic       iszero;
        logic       sign;
        logic [3:0] exp;
        logic [8:0] mant;
    } mac_dec_fields;

endpackage

// File: rtl/mac_decode_arbiter_if.sv
// Operand request and decoded-beat bus of mac_decode_arbiter.
interface mac_decode_arbiter_if;
    import mac_pkg::*;

    logic [1:0]          i_req_valid;
    logic [1:0]          o_req_ready;
    mac_datatype [1:0]   i_req_datatype;
    logic [1:0][8:0]     i_req_data;
    logic                o_dec_valid;
    logic                i_dec_ready;
    logic                o_dec_src;
    logic                o_dec_iszero;
    logic                o_dec_sign;
    logic [3:0]          o_dec_exp;
    logic [8:0]          o_dec_mant;

    modport slave (
        input  i_req_valid, i_req_datatype, i_req_data,
        input  i_dec_ready,
        output o_req_ready, o_dec_valid, o_dec_src,
        output o_dec_iszero, o_dec_sign,
        output o_dec_exp, o_dec_mant
    );

    modport master (
        output i_req_valid, i_req_datatype, i_req_data,
        output i_dec_ready,
        input  o_req_ready, o_dec_valid, o_dec_src,
        input  o_dec_iszero, o_dec_sign,
        input  o_dec_exp, o_dec_mant
    );

endinterface

// File: rtl/mac_decoder_mid.sv
// Combinational 9-bit operand decoder (FP8 vs. integer layouts).
module mac_decoder_mid
    import mac_pkg::*;
(
    input  mac_datatype   i_datatype,
    input  logic [8:0]    i_data,
    output mac_dec_fields o_fields
);

    logic w_sub;

    assign w_sub = (i_data[6:3] == 4'd0) &&
                   (i_data[2:0] != 3'd0);

    always_comb begin
        o_fields        = '0;
        o_fields.iszero = (i_data == 9'd0);
        o_fields.exp    = i_data[6:3];
        if (i_datatype == MAC_DATATYPE_FP8) begin
            o_fields.sign = i_data[7];
            o_fields.mant = {5'b0, w_sub, i_data[2:0]};
        end else begin
            o_fields.sign = i_data[8];
            o_fields.mant = i_data;
        end
    end

endmodule

// File: rtl/mac_decode_arbiter.sv
// Round-robin burst-lock arbiter sharing one decoder between two loaders.
// Optional saturating accept counters: define MAC_DEC_ARB_STAT_EN.
module mac_decode_arbiter
    import mac_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int STAT_W    = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    mac_decode_arbiter_if.slave bus
`ifdef MAC_DEC_ARB_STAT_EN
    ,
    output logic [1:0][STAT_W-1:0] o_stat_cnt
`endif
);

    localparam logic [3:0] BLAST = 4'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_LEN > 16 || STAT_W < 1)
    begin : g_bad_cfg
        $error("mac_decode_arbiter: bad parameters");
    end

    mac_dec_arb_state r_state, w_state_nxt;
    logic [3:0]    r_bcnt, w_bcnt_nxt, w_bcnt_eff;
    logic          r_lsp, w_lsp_nxt;
    logic [1:0]    w_v;
    logic          w_lock_ok, w_gnt, w_gnt_v;
    logic          w_can, w_acc, w_other_v;
    mac_datatype   w_dt;
    logic [8:0]    w_data;
    mac_dec_fields w_fields, r_fields;
    logic          r_valid, r_src;

    assign w_v    = bus.i_req_valid;
    assign w_dt   = bus.i_req_datatype[w_gnt];
    assign w_data = bus.i_req_data[w_gnt];

    // A lock whose owner dropped valid falls back to the idle rule
    always_comb begin
        w_lock_ok = (r_state == ARB_LOCK0 && w_v[0]) ||
                    (r_state == ARB_LOCK1 && w_v[1]);
        w_gnt_v   = |w_v;
        w_gnt     = 1'b0;
        if (w_lock_ok)
            w_gnt = (r_state == ARB_LOCK1);
        else if (&w_v)
            w_gnt = ~r_lsp;
        else
            w_gnt = w_v[1];
        w_can      = !r_valid || bus.i_dec_ready;
        w_acc      = w_gnt_v && w_can && !i_reset;
        w_other_v  = w_gnt ? w_v[0] : w_v[1];
        w_bcnt_eff = w_lock_ok ? r_bcnt : 4'd0;
        bus.o_req_ready = 2'b00;
        if (w_acc)
            bus.o_req_ready = w_gnt ? 2'b10 : 2'b01;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_lsp_nxt   = r_lsp;
        if (w_acc) begin
            w_lsp_nxt = w_gnt;
            if (w_bcnt_eff == BLAST || !w_other_v) begin
                w_state_nxt = ARB_IDLE;
                w_bcnt_nxt  = 4'd0;
            end else begin
                w_state_nxt = w_gnt ? ARB_LOCK1 : ARB_LOCK0;
                w_bcnt_nxt  = w_bcnt_eff + 4'd1;
            end
        end else if (!w_lock_ok) begin
            w_state_nxt = ARB_IDLE;
            w_bcnt_nxt  = 4'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ARB_IDLE;
            r_bcnt  <= 4'd0;
            r_lsp   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_lsp   <= w_lsp_nxt;
        end
    end

    mac_decoder_mid u_dec (
        .i_datatype (w_dt),
        .i_data     (w_data),
        .o_fields   (w_fields)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= 1'b0;
            r_src    <= 1'b0;
            r_fields <= '0;
        end else if (w_acc) begin
            r_valid  <= 1'b1;
            r_src    <= w_gnt;
            r_fields <= w_fields;
        end else if (bus.i_dec_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign bus.o_dec_valid  = r_valid;
    assign bus.o_dec_src    = r_src;
    assign bus.o_dec_iszero = r_fields.iszero;
    assign bus.o_dec_sign   = r_fields.sign;
    assign bus.o_dec_exp    = r_fields.exp;
    assign bus.o_dec_mant   = r_fields.mant;

`ifdef MAC_DEC_ARB_STAT_EN
    logic [1:0][STAT_W-1:0] r_stat;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_stat <= '0;
        else if (w_acc && r_stat[w_gnt] != '1)
            r_stat[w_gnt] <= r_stat[w_gnt] + 1'b1;
    end

    assign o_stat_cnt = r_stat;
`endif

endmodule

// File: tb/tb_mac_decode_arbiter.sv
// Scoreboard bench for mac_decode_arbiter (BURST_LEN=4).
module tb_mac_decode_arbiter;
    import mac_pkg::*;

    typedef struct {
        mac_datatype dt;
        logic [8:0]  d;
        int          gap;
    } item_t;

    typedef struct packed {
        logic          src;
        mac_dec_fields f;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_decode_arbiter_if bus();

`ifdef MAC_DEC_ARB_STAT_EN
    logic [1:0][3:0] stat;
    mac_decode_arbiter #(.BURST_LEN(4), .STAT_W(4)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus),
        .o_stat_cnt(stat)
    );
`else
    mac_decode_arbiter #(.BURST_LEN(4), .STAT_W(4)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus)
    );
`endif

    item_t q0[$];
    item_t q1[$];
    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;
    logic [1:0] acc;
    bit    pend [2];
    int    gap [2];
    logic  rst_nxt;
    logic  rdy_nxt;
    exp_t  m_exp, m_got;

    function automatic exp_t mk(bit s, bit z, bit sg,
                                int e, int m);
        exp_t r;
        r.src      = s;
        r.f.iszero = z;
        r.f.sign   = sg;
        r.f.exp    = 4'(e);
        r.f.mant   = 9'(m);
        return r;
    endfunction

    // req0 item k: data k*8 (INT8) -> exp k, sign 0, mant k*8
    // req1 item k: data 256+k*8    -> exp k, sign 1, mant 256+k*8
    function automatic exp_t xa(int k);
        return mk(1'b0, 1'b0, 1'b0, k, k * 8);
    endfunction

    function automatic exp_t xb(int k);
        return mk(1'b1, 1'b0, 1'b1, k, 256 + k * 8);
    endfunction

    task automatic ia(int k, int g);
        item_t it;
        it = '{MAC_DATATYPE_INT8, 9'(k * 8), g};
        q0.push_back(it);
    endtask

    task automatic ib(int k);
        item_t it;
        it = '{MAC_DATATYPE_INT8, 9'(256 + k * 8), 0};
        q1.push_back(it);
    endtask

    task automatic chk(string n, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, got, want);
        end
    endtask

    task automatic present(int i);
        item_t it;
        pend[i] = 1'b0;
        if (i == 0 && q0.size() > 0) begin
            it = q0.pop_front();
            pend[i] = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
            it = q1.pop_front();
            pend[i] = 1'b1;
        end
        if (pend[i]) begin
            bus.i_req_datatype[i] = it.dt;
            bus.i_req_data[i]     = it.d;
            gap[i]                = it.gap;
            bus.i_req_valid[i]    = (it.gap == 0);
        end else begin
            bus.i_req_valid[i] = 1'b0;
        end
    endtask

    task automatic cyc();
        acc = bus.i_req_valid & bus.o_req_ready;
        @(posedge clk);
        #1;
        rst = rst_nxt;
        bus.i_dec_ready = rdy_nxt;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                present(i);
            end else if (pend[i] && gap[i] > 0) begin
                gap[i]--;
                if (gap[i] == 0) bus.i_req_valid[i] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic start();
        present(0);
        present(1);
        #1;
    endtask

    task automatic run(string n, int want);
        int c;
        c = 0;
        while ((pend[0] || pend[1]) && c < 100) begin
            cyc();
            c++;
        end
        chk({n, "_cycles"}, c, want);
        #1;
        chk({n, "_sb_left"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        bus.i_req_valid = 2'b00;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        rst_nxt = 1'b1;
        cyc();
        rst_nxt = 1'b0;
        cyc();
    endtask

    always @(negedge clk) begin
        total++;
        if (bus.o_req_ready == 2'b11) begin
            bad++;
            $display("FAIL ready_onehot got=%b want<=1 bit",
                     bus.o_req_ready);
        end
        if (bus.o_dec_valid && bus.i_dec_ready) begin
            total++;
            m_got = {bus.o_dec_src, bus.o_dec_iszero,
                     bus.o_dec_sign, bus.o_dec_exp,
                     bus.o_dec_mant};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got=%h want=none",
                         m_got);
            end else begin
                m_exp = sb.pop_front();
                if (m_got !== m_exp) begin
                    bad++;
                    $display("FAIL sb_beat got=%h want=%h",
                             m_got, m_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        rst = 1'b1;
        rst_nxt = 1'b1;
        rdy_nxt = 1'b1;
        bus.i_dec_ready    = 1'b1;
        bus.i_req_valid    = 2'b00;
        bus.i_req_data     = '0;
        bus.i_req_datatype = {MAC_DATATYPE_INT8,
                              MAC_DATATYPE_INT8};
        repeat (2) @(negedge clk);
        bus.i_req_valid = 2'b11;
        #1;
        chk("rst_ready", bus.o_req_ready, 0);
        chk("rst_valid", bus.o_dec_valid, 0);
        chk("rst_src", bus.o_dec_src, 0);
        chk("rst_iszero", bus.o_dec_iszero, 0);
        chk("rst_sign", bus.o_dec_sign, 0);
        chk("rst_exp", bus.o_dec_exp, 0);
        chk("rst_mant", bus.o_dec_mant, 0);
        bus.i_req_valid = 2'b00;
        rst_nxt = 1'b0;
        cyc();
        chk("idle_valid", bus.o_dec_valid, 0);

        // decode vectors from req0 alone
        it = '{MAC_DATATYPE_FP8, 9'h045, 0};
        q0.push_back(it);
        it = '{MAC_DATATYPE_FP8, 9'h003, 0};
        q0.push_back(it);
        it = '{MAC_DATATYPE_FP8, 9'h000, 0};
        q0.push_back(it);
        it = '{MAC_DATATYPE_INT8, 9'h1FF, 0};
        q0.push_back(it);
        sb.push_back(mk(0, 0, 0, 8, 9'h005));
        sb.push_back(mk(0, 0, 0, 0, 9'h00B));
        sb.push_back(mk(0, 1, 0, 0, 9'h000));
        sb.push_back(mk(0, 0, 1, 15, 9'h1FF));
        start();
        run("decode", 4);

        // both held valid: 0,0,0,0,1,1,1,1,0
        do_reset();
        for (int k = 1; k <= 5; k++) ia(k, 0);
        for (int k = 1; k <= 4; k++) ib(k);
        for (int k = 1; k <= 4; k++) sb.push_back(xa(k));
        for (int k = 1; k <= 4; k++) sb.push_back(xb(k));
        sb.push_back(xa(5));
        start();
        run("burst", 9);

        // req0 drops after 2 beats; req1 takes the slot
        do_reset();
        ia(1, 0); ia(2, 0); ia(3, 1);
        ia(4, 0); ia(5, 0); ia(6, 0); ia(7, 0);
        ib(1); ib(2); ib(3);
        sb.push_back(xa(1)); sb.push_back(xa(2));
        sb.push_back(xb(1));
        for (int k = 3; k <= 6; k++) sb.push_back(xa(k));
        sb.push_back(xb(2)); sb.push_back(xb(3));
        sb.push_back(xa(7));
        start();
        run("drop", 10);

        // backpressure for 3 cycles
        do_reset();
        ia(1, 0); ia(2, 0); ia(3, 0);
        sb.push_back(xa(1)); sb.push_back(xa(2));
        sb.push_back(xa(3));
        start();
        rdy_nxt = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc();
            chk("bp_valid", bus.o_dec_valid, 1);
            chk("bp_ready", bus.o_req_ready, 0);
            chk("bp_src", bus.o_dec_src, 0);
            chk("bp_mant", bus.o_dec_mant, 8);
        end
        rdy_nxt = 1'b1;
        run("bp", 3);

        // reset mid-burst discards the held beat
        do_reset();
        for (int k = 1; k <= 6; k++) ia(k, 0);
        ib(1); ib(2);
        sb.push_back(xa(1));
        start();
        cyc();
        rst_nxt = 1'b1;
        rdy_nxt = 1'b0;
        cyc();
        chk("mid_rst_ready", bus.o_req_ready, 0);
        rst_nxt = 1'b0;
        rdy_nxt = 1'b1;
        cyc();
        chk("post_rst_valid", bus.o_dec_valid, 0);
        chk("post_rst_src", bus.o_dec_src, 0);
        chk("post_rst_exp", bus.o_dec_exp, 0);
        chk("post_rst_mant", bus.o_dec_mant, 0);
        chk("post_rst_ready", bus.o_req_ready, 1);
        for (int k = 3; k <= 6; k++) sb.push_back(xa(k));
        sb.push_back(xb(1)); sb.push_back(xb(2));
        run("rst", 6);

`ifdef MAC_DEC_ARB_STAT_EN
        do_reset();
        chk("stat_clr1", stat[1], 0);
        for (int k = 0; k < 20; k++) begin
            ib(1);
            sb.push_back(xb(1));
        end
        start();
        run("stat", 20);
        chk("stat_sat1", stat[1], 15);
        chk("stat_zero0", stat[0], 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
